mac_array_gen: RTL

- Parametrised weight-stationary systolic MAC array of ROW x COL processing elements (PEs), generalised from the fixed 8x8 array.
- Internally skews per-row instruction and west data by row index (any ROW), or broadcasts them.
- Supports signed or unsigned activations, one-shot per-PE weight capture with a re-arm pulse, and per-column result valid.
- Sits between the input/weight SRAM feeders and the output/accumulation stage.

---
 rtl/mac_array_gen_if.sv | 33 +++
 rtl/mac_array_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/mac_array_gen_if.sv
// mac_array_gen_if: groups the data, instruction and control signals that
// connect the systolic MAC array to its feeders and to the output stage.
//   master : drives in_w, inst_w, in_n, mode, data_mode, wt_reload
//            and observes out_s and valid (feeder / testbench side)
//   slave  : the array itself
// Handshake: there is no backpressure. Every input is sampled on every rising
// clock edge. valid[c] is a qualifier only: it marks the cycles in which
// out_s column c holds a freshly computed bottom-row psum.
interface mac_array_gen_if #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8
);
    logic [ROW*BW-1:0]      in_w;
    logic [1:0]             inst_w;
    logic [PSUM_BW*COL-1:0] in_n;
    logic                   mode;
    logic                   data_mode;
    logic                   wt_reload;
    logic [PSUM_BW*COL-1:0] out_s;
    logic [COL-1:0]         valid;

    modport master (
        output in_w, inst_w, in_n, mode, data_mode, wt_reload,
        input  out_s, valid
    );

    modport slave (
        input  in_w, inst_w, in_n, mode, data_mode, wt_reload,
        output out_s, valid
    );
endinterface

// File: rtl/mac_array_gen.sv
// mac_array_gen: weight-stationary systolic MAC array of ROW x COL PEs.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous, active-high reset
//   bus    : mac_array_gen_if.slave
//            in_w/inst_w  west data and instruction (bit1 execute, bit0 load)
//            in_n         north psums into row 0
//            mode         0: activations unsigned, 1: signed (weights signed)
//            data_mode    1: broadcast row inputs, 0: skew by row index
//            wt_reload    re-arms weight capture in every PE
//            out_s/valid  bottom-row psums and per-column execute-valid
module mac_array_gen #(
    parameter int BW      = 4,
    parameter int PSUM_BW = 16,
    parameter int ROW     = 8,
    parameter int COL     = 8
) (
    input logic           clk,
    input logic           reset,
    mac_array_gen_if.slave bus
);
    // Row input word layout: {inst[1:0], data[BW-1:0]}
    localparam int IW = BW + 2;

    logic [1:0]        stage_inst_q;
    logic [ROW*BW-1:0] stage_w_q;
    logic [IW-1:0]     row_in [ROW];

    // Neighbour-visible PE state, one element driven per PE.
    logic [BW-1:0]      pe_a     [ROW][COL];
    logic [1:0]         pe_inst  [ROW][COL];
    logic [PSUM_BW-1:0] pe_psum  [ROW][COL];
    logic               pe_valid [ROW][COL];

    always_ff @(posedge clk) begin
        if (reset) begin
            stage_inst_q <= '0;
            stage_w_q    <= '0;
        end else begin
            stage_inst_q <= bus.inst_w;
            stage_w_q    <= bus.in_w;
        end
    end

    // Row r gets an r-deep delay line. The lines shift regardless of
    // data_mode, so flipping data_mode only changes which tap is used.
    for (genvar r = 0; r < ROW; r++) begin : g_row
        logic [IW-1:0] stage0;
        assign stage0 = {stage_inst_q, stage_w_q[BW*r +: BW]};

        if (r == 0) begin : g_direct
            assign row_in[r] = stage0;
        end else begin : g_skew
            logic [IW-1:0] line_q [r];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < r; i++) line_q[i] <= '0;
                end else begin
                    line_q[0] <= stage0;
                    for (int i = 1; i < r; i++) line_q[i] <= line_q[i-1];
                end
            end
            assign row_in[r] = bus.data_mode ? stage0 : line_q[r-1];
        end
    end

    for (genvar r = 0; r < ROW; r++) begin : g_pe_r
        for (genvar c = 0; c < COL; c++) begin : g_pe_c
            logic [BW-1:0]      a_q, w_q, w_d, west_a;
            logic [1:0]         inst_q, inst_d, west_i;
            logic [PSUM_BW-1:0] psum_q, psum_d, north, w_x, a_x, prod;
            logic               valid_q, valid_d, ld_rdy_q, ld_rdy_d, cap;

            if (c == 0) begin : g_west_row
                assign west_a = row_in[r][BW-1:0];
                assign west_i = row_in[r][IW-1:BW];
            end else begin : g_west_pe
                assign west_a = pe_a[r][c-1];
                assign west_i = pe_inst[r][c-1];
            end

            if (r == 0) begin : g_north_in
                assign north = bus.in_n[PSUM_BW*c +: PSUM_BW];
            end else begin : g_north_pe
                assign north = pe_psum[r-1][c];
            end

            always_comb begin
                // A reload edge re-arms but never captures.
                cap = west_i[0] & ld_rdy_q & ~bus.wt_reload;

                // Both operands extended to PSUM_BW; the low PSUM_BW bits of
                // the product are the wrapped signed result.
                w_x = {PSUM_BW{w_q[BW-1]}};
                w_x[BW-1:0] = w_q;
                a_x = {PSUM_BW{bus.mode & west_a[BW-1]}};
                a_x[BW-1:0] = west_a;
                prod = w_x * a_x;

                w_d      = cap ? west_a : w_q;
                ld_rdy_d = bus.wt_reload ? 1'b1 : (cap ? 1'b0 : ld_rdy_q);
                // A captured word is consumed: the load bit stops here.
                inst_d   = {west_i[1], west_i[0] & ~cap};
                valid_d  = west_i[1];
                psum_d   = west_i[1] ? (north + prod) : psum_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q      <= '0;
                    w_q      <= '0;
                    inst_q   <= '0;
                    psum_q   <= '0;
                    valid_q  <= 1'b0;
                    ld_rdy_q <= 1'b1;
                end else begin
                    a_q      <= west_a;
                    w_q      <= w_d;
                    inst_q   <= inst_d;
                    psum_q   <= psum_d;
                    valid_q  <= valid_d;
                    ld_rdy_q <= ld_rdy_d;
                end
            end

            assign pe_a[r][c]     = a_q;
            assign pe_inst[r][c]  = inst_q;
            assign pe_psum[r][c]  = psum_q;
            assign pe_valid[r][c] = valid_q;
        end
    end

    for (genvar c = 0; c < COL; c++) begin : g_out
        assign bus.out_s[PSUM_BW*c +: PSUM_BW] = pe_psum[ROW-1][c];
        assign bus.valid[c]                    = pe_valid[ROW-1][c];
    end
endmodule
